trace_accumulator: RTL and testbench

- Upstream feeder of the stokes/antistokes ratio divider stage in the Raman DTS chain.
- Captures one ADC sample per range point after each laser trigger and sums each point over MEASURES sweeps.
- Alternates between stokes and antistokes channels, one full accumulation per channel.
- Produces the point/measure counters, the channel flag and the final per-point sums consumed by the divider stage.

---
 rtl/trace_accumulator_if.sv | 36 +++
 rtl/trace_accumulator.sv | 175 +++++++++++++++++
 tb/tb_trace_accumulator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/trace_accumulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_accumulator_if                                                       |
// | ADC/trigger input bundle and per-point sum/counter outputs.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface trace_accumulator_if #(
  parameter int DATA_W = 12,
  parameter int SUM_W  = 29,
  parameter int PT_W   = 11,
  parameter int MS_W   = 17
);
  logic              trig;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic [MS_W-1:0]   MEASURES;
  logic [PT_W-1:0]   POINTS;
  logic [PT_W-1:0]   cnt_point;
  logic [MS_W-1:0]   cnt_measure;
  logic              switch;
  logic              sum_valid;
  logic [PT_W-1:0]   sum_addr;
  logic [SUM_W-1:0]  sum_out;
  logic              busy;

  modport master (
    output trig, adc_valid, adc_data, MEASURES, POINTS,
    input  cnt_point, cnt_measure, switch, sum_valid, sum_addr, sum_out, busy
  );

  modport slave (
    input  trig, adc_valid, adc_data, MEASURES, POINTS,
    output cnt_point, cnt_measure, switch, sum_valid, sum_addr, sum_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/trace_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_accumulator                                                          |
// | Per-point multi-sweep ADC accumulation, alternating stokes/antistokes.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module trace_accumulator #(
  parameter int DATA_W = 12,
  parameter int SUM_W  = 29,
  parameter int PT_W   = 11,
  parameter int MS_W   = 17,
  parameter int TAIL   = 32
) (
  input wire logic          clk,
  input wire logic          rst,
  trace_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_SWEEP = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PT_W-1:0]   r_cnt_point,   w_pt_nxt;
  logic [MS_W-1:0]   r_cnt_measure, w_ms_nxt;
  logic              r_switch,      w_sw_nxt;
  logic [PT_W-1:0]   r_points;
  logic [MS_W-1:0]   r_meas;
  logic              w_accept;
  logic              w_start;

  logic [PT_W-1:0]   w_pts_last;
  logic [PT_W-1:0]   w_tail_last;
  logic              w_meas_last;

  logic              r_s1_vld;
  logic [PT_W-1:0]   r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_clr;
  logic              r_s1_fin;
  logic [SUM_W-1:0]  r_rd_data;
  logic [SUM_W-1:0]  w_sum;

  logic              r_sum_valid;
  logic [PT_W-1:0]   r_sum_addr;
  logic [SUM_W-1:0]  r_sum_out;

  logic [SUM_W-1:0]  r_mem [0:(1<<PT_W)-1];

  assign w_pts_last  = r_points - PT_W'(1);
  assign w_tail_last = r_points + PT_W'(TAIL - 1);
  assign w_meas_last = (r_cnt_measure == (r_meas - MS_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_ARM;
      r_cnt_point   <= '0;
      r_cnt_measure <= '0;
      r_switch      <= 1'b1;
      r_points      <= '0;
      r_meas        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt_point   <= w_pt_nxt;
      r_cnt_measure <= w_ms_nxt;
      r_switch      <= w_sw_nxt;
      // Channel geometry is frozen from the first trigger of each channel
      if (w_start) begin
        r_points <= bus.POINTS;
        r_meas   <= bus.MEASURES;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pt_nxt    = r_cnt_point;
    w_ms_nxt    = r_cnt_measure;
    w_sw_nxt    = r_switch;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      ST_ARM: begin
        if (bus.trig) begin
          w_state_nxt = ST_SWEEP;
          w_pt_nxt    = '0;
          w_start     = (r_cnt_measure == '0);
        end
      end
      ST_SWEEP: begin
        if (bus.adc_valid) begin
          w_accept = 1'b1;
          w_pt_nxt = r_cnt_point + PT_W'(1);
          if (r_cnt_point == w_pts_last) begin
            w_state_nxt = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (r_cnt_point == w_tail_last) begin
          w_state_nxt = ST_ARM;
          w_pt_nxt    = '0;
          if (w_meas_last) begin
            w_ms_nxt = '0;
            w_sw_nxt = ~r_switch;
          end else begin
            w_ms_nxt = r_cnt_measure + MS_W'(1);
          end
        end else begin
          w_pt_nxt = r_cnt_point + PT_W'(1);
        end
      end
      default: w_state_nxt = ST_ARM;
    endcase
  end

  // First sweep of a channel discards whatever the RAM holds for that point
  assign w_sum = (r_s1_clr ? '0 : r_rd_data) + {{(SUM_W-DATA_W){1'b0}}, r_s1_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
      r_s1_clr  <= 1'b0;
      r_s1_fin  <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_addr <= r_cnt_point;
        r_s1_data <= bus.adc_data;
        r_s1_clr  <= (r_cnt_measure == '0);
        r_s1_fin  <= w_meas_last;
      end
    end
  end

  // Addresses within a sweep strictly increase, so the read of the next
  // point never collides with the write of the previous one.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_data <= r_mem[r_cnt_point];
    end
    if (r_s1_vld) begin
      r_mem[r_s1_addr] <= w_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_valid <= 1'b0;
      r_sum_addr  <= '0;
      r_sum_out   <= '0;
    end else begin
      r_sum_valid <= r_s1_vld & r_s1_fin;
      if (r_s1_vld & r_s1_fin) begin
        r_sum_addr <= r_s1_addr;
        r_sum_out  <= w_sum;
      end
    end
  end

  assign bus.cnt_point   = r_cnt_point;
  assign bus.cnt_measure = r_cnt_measure;
  assign bus.switch      = r_switch;
  assign bus.sum_valid   = r_sum_valid;
  assign bus.sum_addr    = r_sum_addr;
  assign bus.sum_out     = r_sum_out;
  assign bus.busy        = (r_state != ST_ARM);

endmodule
`default_nettype wire

// File: tb/tb_trace_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trace_accumulator                                                       |
// | Randomised sweeps compared against a per-point running-sum model.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_trace_accumulator;
  localparam int DATA_W = 12;
  localparam int SUM_W  = 29;
  localparam int PT_W   = 11;
  localparam int MS_W   = 17;
  localparam int TAIL   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  trace_accumulator_if #(.DATA_W(DATA_W), .SUM_W(SUM_W), .PT_W(PT_W), .MS_W(MS_W)) bus();

  trace_accumulator #(
    .DATA_W(DATA_W), .SUM_W(SUM_W), .PT_W(PT_W), .MS_W(MS_W), .TAIL(TAIL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int     addr;
    longint sum;
    int     cyc;
  } exp_t;
  exp_t   q[$];
  bit     sw = 1'b1;
  longint acc[];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.sum_valid === 1'b1) begin
      if (q.size() == 0) begin
        check_val("sum_valid_unexpected", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check_val("sum_addr", 64'(bus.sum_addr), 64'(e.addr));
        check_val("sum_out", 64'(bus.sum_out), 64'(e.sum));
        check_val("sum_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.adc_valid = 1'b0;
    bus.trig      = 1'b0;
  endtask

  task automatic check_reset_state();
    check_val("rst_cnt_point", 64'(bus.cnt_point), 64'd0);
    check_val("rst_cnt_measure", 64'(bus.cnt_measure), 64'd0);
    check_val("rst_switch", 64'(bus.switch), 64'd1);
    check_val("rst_sum_valid", 64'(bus.sum_valid), 64'd0);
    check_val("rst_sum_addr", 64'(bus.sum_addr), 64'd0);
    check_val("rst_sum_out", 64'(bus.sum_out), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
  endtask

  // mode: 0 random samples, 1 constant cval, 2 ramp p+1
  task automatic run_channel(input int meas, input int pts, input int mode, input int cval,
                             input int maxgap, input bit noise, input int ab_m, input int ab_p);
    int last;
    int v;
    int g;
    int n;
    acc = new[pts];
    bus.MEASURES = MS_W'(meas);
    bus.POINTS   = PT_W'(pts);
    for (int m = 0; m < meas; m++) begin
      bus.trig      = 1'b1;
      bus.adc_valid = 1'b1;
      bus.adc_data  = DATA_W'($urandom);
      tick();
      last = cyc;
      for (int p = 0; p < pts; p++) begin
        check_val("cnt_point", 64'(bus.cnt_point), 64'(p));
        if (p == 0) begin
          check_val("cnt_measure", 64'(bus.cnt_measure), 64'(m));
          check_val("switch", 64'(bus.switch), 64'(sw));
          check_val("busy", 64'(bus.busy), 64'd1);
        end
        v = (mode == 1) ? cval : (mode == 2) ? p + 1 : int'($urandom_range(0, 4095));
        bus.adc_valid = 1'b1;
        bus.adc_data  = DATA_W'(v);
        if (m == ab_m && p == ab_p) begin
          #2 rst = 1'b1;
          #1 q.delete();
          check_reset_state();
          tick();
          rst = 1'b0;
          sw  = 1'b1;
          return;
        end
        acc[p] = ((m == 0) ? 64'sd0 : acc[p]) + longint'(v);
        if (m == meas - 1) q.push_back('{p, acc[p], cyc + 2});
        last = cyc;
        if (p < pts - 1) begin
          tick();
          g = int'($urandom_range(0, maxgap));
          repeat (g) begin
            bus.trig = noise;
            tick();
          end
        end
      end
      n = 0;
      do begin
        tick();
        n++;
        if (noise && cyc == last + 2) bus.trig = 1'b1;
        if (cyc == last + TAIL) check_val("tail_last_point", 64'(bus.cnt_point), 64'(pts + TAIL - 1));
      end while (bus.busy !== 1'b0 && n < TAIL + 20);
      check_val("arm_after_tail", 64'(cyc - last), 64'(TAIL + 1));
      check_val("cnt_point_arm", 64'(bus.cnt_point), 64'd0);
      if (m == meas - 1) sw = ~sw;
      check_val("cnt_measure_next", 64'(bus.cnt_measure), 64'((m + 1) % meas));
      check_val("switch_next", 64'(bus.switch), 64'(sw));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.trig      = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    bus.MEASURES  = MS_W'(1);
    bus.POINTS    = PT_W'(1);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    tick();

    run_channel(1, 4, 2, 0, 2, 1'b0, -1, -1);
    run_channel(3, 8, 1, 100, 2, 1'b1, -1, -1);
    run_channel(2, 16, 1, 4095, 0, 1'b0, -1, -1);
    run_channel(3, 20, 0, 0, 3, 1'b1, -1, -1);
    run_channel(2, 8, 0, 0, 0, 1'b0, 1, 5);
    run_channel(2, 8, 0, 0, 1, 1'b0, -1, -1);
    run_channel(500, 2, 1, 4095, 0, 1'b0, -1, -1);

    repeat (5) tick();
    check_val("expected_left", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
